// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared defaults and slot encoding for the two-lane PHY
package pcie_phy_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_t;

endpackage

// File: rtl/lane_word_counter.sv
// rtl/lane_word_counter.sv - wrap-around delivered-word counter with increment enable
module lane_word_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Wraps modulo 2^CNT_W; debug-only, so no saturation or overflow flag.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/demux_striping.sv
// rtl/demux_striping.sv - two-lane receive un-striping; DEMUX_STRIPING_PAIR_ALIGN_EN aligns lane pairs
module demux_striping
  import pcie_phy_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_input,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic [CNT_W-1:0]  word_cnt_0,
  output logic [CNT_W-1:0]  word_cnt_1
);

  slot_t sel;
  logic  inc_0;
  logic  inc_1;

`ifdef DEMUX_STRIPING_PAIR_ALIGN_EN
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;

  // Lane-0 word waits in the hold register so both lanes update on the SLOT1 edge.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel        <= SLOT0;
      lane_0     <= '0;
      lane_1     <= '0;
      valid_0    <= 1'b0;
      valid_1    <= 1'b0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      case (sel)
        SLOT0: begin
          hold_valid <= valid_in;
          if (valid_in) hold_data <= data_input;
          sel <= SLOT1;
        end
        default: begin
          valid_0 <= hold_valid;
          if (hold_valid) lane_0 <= hold_data;
          valid_1 <= valid_in;
          if (valid_in) lane_1 <= data_input;
          sel <= SLOT0;
        end
      endcase
    end
  end

  assign inc_0 = (sel == SLOT1) && hold_valid;
  assign inc_1 = (sel == SLOT1) && valid_in;
`else
  // The slot toggles every edge regardless of valid_in, mirroring the transmit mux.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel     <= SLOT0;
      lane_0  <= '0;
      lane_1  <= '0;
      valid_0 <= 1'b0;
      valid_1 <= 1'b0;
    end else begin
      case (sel)
        SLOT0: begin
          valid_0 <= valid_in;
          if (valid_in) lane_0 <= data_input;
          sel <= SLOT1;
        end
        default: begin
          valid_1 <= valid_in;
          if (valid_in) lane_1 <= data_input;
          sel <= SLOT0;
        end
      endcase
    end
  end

  assign inc_0 = (sel == SLOT0) && valid_in;
  assign inc_1 = (sel == SLOT1) && valid_in;
`endif

  lane_word_counter #(.CNT_W(CNT_W)) u_cnt_0 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .inc    (inc_0),
    .count  (word_cnt_0)
  );

  lane_word_counter #(.CNT_W(CNT_W)) u_cnt_1 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .inc    (inc_1),
    .count  (word_cnt_1)
  );

endmodule

// File: doc/demux_striping.md
# demux_striping

Receive-side un-striping block for the two-lane PCIe-style physical layer. Takes the single serialized 32-bit word stream running on `clk_2f` and redistributes it alternately onto lane 0 and lane 1, restoring the per-lane words and valids that the transmit-side striping mux interleaved. It sits between the deserializer/byte-assembly stage and the per-lane downstream logic, and keeps per-lane delivered-word counters for link bring-up debug.

## Interface
Parameters:
- `DATA_W`, 32, word width of the input stream and of each lane.
- `CNT_W`, 16, width of each per-lane delivered-word counter.

Ports:
- `clk_2f`  in  1  double-rate clock, the only clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_input`  in  DATA_W  interleaved word stream.
- `valid_in`  in  1  `data_input` carries a valid word this cycle.
- `lane_0`  out  DATA_W  recovered lane 0 word.
- `lane_1`  out  DATA_W  recovered lane 1 word.
- `valid_0`  out  1  `lane_0` valid.
- `valid_1`  out  1  `lane_1` valid.
- `word_cnt_0`  out  CNT_W  count of valid words delivered on lane 0.
- `word_cnt_1`  out  CNT_W  count of valid words delivered on lane 1.

## Operation
- Two-state slot FSM, `SLOT0` / `SLOT1`, registered `sel`. Reset state `SLOT0`.
- FSM toggles on every `clk_2f` edge out of reset, independent of `valid_in`. An invalid cycle consumes its lane slot, mirroring the transmit mux, which emits `valid_out=0` for an empty lane slot.
- `SLOT0` edge: `lane_0 <= data_input` only if `valid_in`; `valid_0 <= valid_in`; `word_cnt_0` increments if `valid_in`.
- `SLOT1` edge: same behaviour for lane 1.
- Lane data registers hold their last value when not loaded. Consumers qualify data with `valid_x` only.
- The valid of the lane not being sampled holds its previous value (non-aligned mode).
- Counters wrap modulo 2^CNT_W with no saturation and no flag.
- Reset values: `lane_0`, `lane_1` = 0; `valid_0`, `valid_1` = 0; both counters 0; `sel` = `SLOT0`; pair-hold registers (if present) = 0.
- Reset asserted mid-stream: all state clears on the reset edge. The first word after deassertion is always lane 0.

## Timing
- Non-aligned: a word sampled at edge N appears on its lane output after edge N, a latency of 1 `clk_2f` cycle. Each lane output updates every 2 cycles.
- `valid_x` is high for 2 cycles per valid lane word: one lane-clock period at `clk_f`.
- Counter updates coincide with the `valid_x` update edge.
- No back-pressure. The block always accepts input.

## Configuration
- `DEMUX_STRIPING_PAIR_ALIGN_EN` defined:
  - The `SLOT0` word and valid are captured into a hold register instead of driving outputs.
  - On the `SLOT1` edge, `lane_0`/`valid_0` load from the hold register and `lane_1`/`valid_1` load from input, so both lanes update on the same edge.
  - Latency is 2 cycles for the lane-0 word and 1 cycle for the lane-1 word.
  - Per-lane valids remain independent.
  - Counters increment on the `SLOT1` edge.
- Not defined: no hold register; lanes update on their own slot edges as described in Operation.

## Structure
- Shared package `pcie_phy_pkg`: `DATA_W` default, slot-state encoding (`SLOT0=1'b0`, `SLOT1=1'b1`), counter width default.
- One natural sub-module: `lane_word_counter`, a CNT_W wrap-around counter with increment enable and synchronous reset, instantiated twice.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles with random input. Expect all outputs at 0 and `sel`=`SLOT0`.
- **Continuous stream:** `valid_in`=1 with words 0xA0000000, 0xB0000000, 0xA0000001, 0xB0000001.
  - `lane_0` gets 0xA0000000 then 0xA0000001; `lane_1` gets 0xB0000000 then 0xB0000001.
  - Counters read 2/2.
  - With the pair-align macro, each pair appears on the same edge.
- **Gap on lane 1:** sequence (0x11,v=1), (0x22,v=0), (0x33,v=1).
  - `valid_1`=0 for its slot and `lane_1` holds its prior value.
  - 0x33 lands on `lane_0`. Counters read 2/0.
- **Loopback:** drive the transmit striping mux with random lane words and valids, and feed its `data_output`/`valid_out` into this block. Recovered lanes must match the originals word for word.
- **Counter wrap:** with `CNT_W`=4, send 17 valid pairs. Expect both counters = 1.
- **Mid-stream reset:** assert reset at a `SLOT1` cycle. After release, the next word 0x55 goes to `lane_0`.
